imm_extend_unit: RTL
====================

IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 The block SHALL have parameter IN_W, default 12, meaning the immediate input width in bits.
REQ-002 The block SHALL have parameter OUT_W, default 16, meaning the datapath output width in bits.
REQ-003 The block SHALL have parameter SHIFT, default 1, meaning the left-shift amount for branch-offset mode.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port flush, input, 1 bit, synchronous discard of all buffered results.
REQ-007 The block SHALL have port in_valid, input, 1 bit, an immediate is offered.
REQ-008 The block SHALL have port in_ready, output, 1 bit, the block accepts the offered immediate this cycle.
REQ-009 The block SHALL have port in_imm, input, IN_W bits, the raw immediate field.
REQ-010 The block SHALL have port in_mode, input, 2 bits, the extension mode.
REQ-011 The block SHALL have port out_valid, output, 1 bit, out_imm holds a result.
REQ-012 The block SHALL have port out_ready, input, 1 bit, the consumer takes the result this cycle.
REQ-013 The block SHALL have port out_imm, output, OUT_W bits, the extended immediate.
REQ-014 The block SHALL have port out_neg, output, 1 bit, equal to out_imm[OUT_W-1].

Function
REQ-015 A transfer SHALL occur on an input edge with in_valid && in_ready, and on an output edge with out_valid && out_ready.
REQ-016 Mode 00 SHALL zero-extend: 0x803 -> 0x0803.
REQ-017 Mode 01 SHALL sign-extend by replicating in_imm[IN_W-1]: 0x803 -> 0xF803; 0x7FF -> 0x07FF.
REQ-018 Mode 10 SHALL sign-extend and then shift left by SHIFT with zero fill: 0x803 -> 0xF006.
REQ-019 Mode 11 SHALL place in_imm in out_imm[OUT_W-1:OUT_W-IN_W] and fill the lower bits with zeros: 0xABC -> 0xABC0.
REQ-020 Extension SHALL be computed combinationally before the register; the result SHALL reach out_imm exactly 1 cycle after the accepting edge.
REQ-021 Results SHALL leave in acceptance order, with none dropped or duplicated while flush=0.
REQ-022 out_imm and out_neg SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 With flush=1, all entries SHALL be invalidated at the edge, and any input offered that cycle SHALL be discarded.
REQ-024 With flush=1, in_ready SHALL still follow its normal rule.
REQ-025 When the buffer is empty, an accepted input SHALL load directly into the output register.
REQ-026 A simultaneous input and output transfer SHALL keep occupancy unchanged.
REQ-027 Elaboration SHALL fail when OUT_W < IN_W+SHIFT or IN_W < 2.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear out_valid, out_imm, out_neg, and all buffer valid bits.
REQ-029 During reset, in_ready SHALL be 0.
REQ-030 From the first edge after deassertion, in_ready SHALL be 1.
REQ-031 Reset asserted mid-transfer SHALL discard all in-flight results.

Configuration
REQ-032 With macro IMM_EXT_SKID_EN defined, the block SHALL contain a 2-entry skid buffer.
REQ-033 With IMM_EXT_SKID_EN defined, in_ready SHALL be a registered signal equal to !skid_full, with no combinational path from out_ready.
REQ-034 With IMM_EXT_SKID_EN defined, full-throughput streaming SHALL be sustained under intermittent out_ready.
REQ-035 Without IMM_EXT_SKID_EN, the block SHALL use a single output register with in_ready = !out_valid || out_ready, combinational.
REQ-036 Extension results, ordering, and latency SHALL be identical in both builds.

Structure
REQ-037 The mode encodings (MODE_ZERO=00, MODE_SIGN=01, MODE_BRANCH=10, MODE_UPPER=11) SHALL reside in a shared package, imm_ext_pkg, reused by decode.
REQ-038 A combinational sub-module, imm_ext_core, SHALL perform the mode selection and extension; imm_extend_unit SHALL hold only buffering and handshake.

Verification
REQ-039 A bench SHALL cover, with defaults: mode 01, in_imm 0x000/0x003/0x803/0x7FF -> out_imm 0x0000/0x0003/0xF803/0x07FF one cycle later, with out_neg 0/0/1/0.
REQ-040 A bench SHALL cover: modes 00/10/11 with 0x803, 0x803, 0xABC -> 0x0803, 0xF006, 0xABC0.
REQ-041 A bench SHALL cover: a stream of 8 values with out_ready low for 3 cycles mid-stream -> all 8 emerge in order, with held values stable; with SKID_EN, in_ready drops only after 2 are buffered.
REQ-042 A bench SHALL cover: flush asserted with 2 entries buffered and in_valid=1 -> out_valid=0 next cycle, and the offered value is never output.
REQ-043 A bench SHALL cover: rst_n pulled low asynchronously between edges with out_valid=1 -> out_valid and out_imm are 0 immediately, and in_ready is 0 until the first edge after release.
REQ-044 A bench SHALL cover: parameter set IN_W=8, OUT_W=16, SHIFT=2 with mode 10 and 0x80 -> 0xFE00, and mode 11 with 0x80 -> 0x8000.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension datapath: mode encodings
// (also used by instruction decode) and a parameter legality helper.
package imm_ext_pkg;

  // Extension mode as carried on the 2-bit in_mode field.
  typedef enum logic [1:0] {
    MODE_ZERO   = 2'b00,
    MODE_SIGN   = 2'b01,
    MODE_BRANCH = 2'b10,
    MODE_UPPER  = 2'b11
  } imm_mode_e;

  // Number of results the skid buffer can hold behind the output register.
  localparam int unsigned SKID_DEPTH = 2;

  // The extended and shifted immediate must fit in the output word, and a
  // sign bit needs at least one magnitude bit beside it.
  function automatic logic params_ok(input int unsigned in_w, input int unsigned out_w,
                                     input int unsigned shift);
    return (out_w >= in_w + shift) && (in_w >= 2);
  endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: zero, sign, branch (sign then shift) and
// upper (immediate placed in the top bits) modes. No state.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 1
) (
  input  logic [IN_W-1:0]  imm_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] ext_o
);

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;

  assign zext = OUT_W'(imm_i);
  // Size cast of a signed operand replicates the top bit of imm_i.
  assign sext = OUT_W'($signed(imm_i));

  // Select the extension for the requested mode.
  always_comb begin
    ext_o = zext;
    unique case (imm_mode_e'(mode_i))
      MODE_ZERO:   ext_o = zext;
      MODE_SIGN:   ext_o = sext;
      MODE_BRANCH: ext_o = sext << SHIFT;
      MODE_UPPER:  ext_o = zext << (OUT_W - IN_W);
    endcase
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Buffered immediate-extension unit with valid/ready handshakes on both sides.
// Extension is done by imm_ext_core ahead of the output register; this module
// only holds buffering and handshake logic.
// Build option: define IMM_EXT_SKID_EN to add a 2-entry skid buffer behind the
// output register and make in_ready a registered signal. Without it, a single
// output register is used and in_ready is combinational from out_ready.
module imm_extend_unit
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic             out_neg
);

  if (!params_ok(IN_W, OUT_W, SHIFT)) begin : g_bad_params
    $error("imm_extend_unit: need OUT_W >= IN_W+SHIFT and IN_W >= 2");
  end

  logic [OUT_W-1:0] ext;
  logic             in_fire;
  logic             out_fire;

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_imm_q, out_imm_d;
  // Low through reset, high from the first edge after release.
  logic             ready_q, ready_d;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_core (
    .imm_i  (in_imm),
    .mode_i (in_mode),
    .ext_o  (ext)
  );

  assign out_valid = out_valid_q;
  assign out_imm   = out_imm_q;
  assign out_neg   = out_imm_q[OUT_W-1];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;

`ifdef IMM_EXT_SKID_EN

  logic [OUT_W-1:0] skid_data_q [SKID_DEPTH];
  logic [OUT_W-1:0] skid_data_d [SKID_DEPTH];
  logic [1:0]       skid_cnt_q, skid_cnt_d;
  logic             slot_free;
  logic [1:0]       cnt_tmp;

  // Registered ready: exactly "skid buffer not full" for the current state.
  assign in_ready  = ready_q;
  assign slot_free = !out_valid_q || out_ready;

  // Next state: refill the output register from the skid head (or directly
  // from the input when nothing is buffered), then append any accepted input.
  always_comb begin
    out_valid_d = out_valid_q;
    out_imm_d   = out_imm_q;
    skid_data_d = skid_data_q;
    skid_cnt_d  = skid_cnt_q;
    cnt_tmp     = skid_cnt_q;
    ready_d     = 1'b1;
    if (flush) begin
      out_valid_d = 1'b0;
      skid_cnt_d  = 2'd0;
    end else begin
      if (slot_free) begin
        if (skid_cnt_q != 2'd0) begin
          out_valid_d    = 1'b1;
          out_imm_d      = skid_data_q[0];
          skid_data_d[0] = skid_data_q[1];
          cnt_tmp        = skid_cnt_q - 2'd1;
        end else begin
          out_valid_d = in_fire;
          if (in_fire) begin
            out_imm_d = ext;
          end
        end
      end
      // Input goes to the skid buffer unless it loaded the output register.
      if (in_fire && ((skid_cnt_q != 2'd0) || !slot_free)) begin
        skid_data_d[cnt_tmp[0]] = ext;
        cnt_tmp                 = cnt_tmp + 2'd1;
      end
      skid_cnt_d = cnt_tmp;
      ready_d    = (cnt_tmp != 2'(SKID_DEPTH));
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_imm_q      <= '0;
      ready_q        <= 1'b0;
      skid_cnt_q     <= 2'd0;
      skid_data_q[0] <= '0;
      skid_data_q[1] <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_imm_q      <= out_imm_d;
      ready_q        <= ready_d;
      skid_cnt_q     <= skid_cnt_d;
      skid_data_q[0] <= skid_data_d[0];
      skid_data_q[1] <= skid_data_d[1];
    end
  end

`else

  // Single output register: accept when it is empty or being drained.
  assign in_ready = ready_q && (!out_valid_q || out_ready);

  // Next state: flush wins; an accepted input replaces a consumed result.
  always_comb begin
    out_valid_d = out_valid_q;
    out_imm_d   = out_imm_q;
    ready_d     = 1'b1;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_fire) begin
      out_valid_d = 1'b1;
      out_imm_d   = ext;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      ready_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_imm_q   <= out_imm_d;
      ready_q     <= ready_d;
    end
  end

`endif

endmodule
